peridot_hostbridge_rxdecoder: RTL and testbench
===============================================

# peridot_hostbridge_rxdecoder

Receive-side packet decoder for the PERIDOT host bridge. It sits directly downstream of the FT245 phy and consumes its RX byte stream (phy `out_*`). Escape and marker bytes are stripped from the stream. The block emits Avalon-ST packets with start/end-of-packet and channel sideband toward the host-bridge transaction layer.

## Interface

Parameters:
- `CHANNEL_WIDTH`, default 8: width of `out_channel`. Only the low `CHANNEL_WIDTH` bits of a channel byte are kept. Legal range is 1..8.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_ready`  out  1  sink ready; connects to the phy's `out_ready`.
- `in_valid`  in  1  sink valid; driven by the phy's `out_valid`.
- `in_data`  in  8  sink byte; driven by the phy's `out_data`.
- `out_ready`  in  1  source ready from the downstream layer.
- `out_valid`  out  1  source valid.
- `out_data`  out  8  decoded data byte.
- `out_startofpacket`  out  1  SOP qualifier for `out_data`.
- `out_endofpacket`  out  1  EOP qualifier for `out_data`.
- `out_channel`  out  CHANNEL_WIDTH  channel of the current byte.

## Operation

Byte codes:
- 0x7A = SOP marker
- 0x7B = EOP marker
- 0x7C = channel marker
- 0x7D = escape

An input beat is accepted when `in_valid && in_ready`.

Internal state, all cleared by reset:
- Flags: `sop_pend`, `eop_pend`, `chan_pend`, `esc_pend`.
- Registers: `channel_reg` (reset value 0) and the output register set.

Accepted byte B is processed in this priority order:
1. `esc_pend` = 1: the value is V = B XOR 0x20. Clear `esc_pend`.
   - If `chan_pend` = 1: `channel_reg` ← V[CHANNEL_WIDTH-1:0], clear `chan_pend`.
   - Otherwise V is a data byte (rule 4).
2. B = 0x7D: set `esc_pend`. No output is produced. Any other pending flag is kept.
3. `chan_pend` = 1:
   - If B is 0x7A, 0x7B or 0x7C: treat it as a marker (rule 5) and leave `chan_pend` set.
   - Otherwise: `channel_reg` ← B[CHANNEL_WIDTH-1:0], clear `chan_pend`. No output is produced.
4. Data byte (B is not a marker, or V from rule 1):
   - Load `out_data` = value, `out_startofpacket` = `sop_pend`, `out_endofpacket` = `eop_pend`, `out_channel` = `channel_reg`. The channel written by a channel byte in the same beat is not possible, because channel bytes produce no data.
   - Set `out_valid`. Clear `sop_pend` and `eop_pend`.
5. Markers:
   - 0x7A sets `sop_pend`.
   - 0x7B sets `eop_pend`.
   - 0x7C sets `chan_pend`.
   - Repeated markers are idempotent.
   - No framing check: a SOP inside an open packet simply marks the next byte SOP.

Additional rules:
- EOP semantics: the EOP marker precedes the last data byte of the packet. A one-byte packet is therefore 7A 7B D.
- `in_ready` = `!out_valid || out_ready`, combinational. Control bytes are also gated by `in_ready`, which keeps the logic uniform.
- `out_valid` clears when `out_valid && out_ready` and no new data byte is accepted in the same cycle.

## Timing

- Reset values: `out_valid` = 0, `out_data` = 0, `out_startofpacket` = 0, `out_endofpacket` = 0, `out_channel` = 0. `in_ready` = 1 while out of reset with `out_valid` = 0.
- Latency: a data byte accepted at edge N appears with `out_valid` = 1 after edge N; it is visible in cycle N+1.
- Throughput: one input byte per cycle, sustained while `out_ready` = 1. Marker and escape bytes cost one input cycle each and produce no output beat.
- Backpressure: while `out_valid` && !`out_ready`:
  - `in_ready` = 0.
  - All output fields and internal flags hold.
- Simultaneous drain and fill (`out_ready` = 1 with a new data byte accepted): the output register reloads and `out_valid` stays 1, with no bubble.
- Reset asserted mid-packet: all pending flags and `channel_reg` clear immediately, and any held output beat is discarded. Decoding restarts with no SOP pending, so the phy's following bytes are data with SOP = 0 until a 0x7A arrives.

## Test plan

- Stream 7A 7C 03 41 42 7B 43 with `out_ready` = 1. Required response: three beats, each with channel 3:
  - 0x41: SOP=1, EOP=0
  - 0x42: SOP=0, EOP=0
  - 0x43: SOP=0, EOP=1
  
  Beats arrive one cycle after each accepted data byte.
- Stream 7A 7B 7D 5A. Required response: one beat, `out_data` = 0x7A, SOP=1, EOP=1. The escaped channel sequence 7C 7D 5D sets `out_channel` = 0x7D for the next data beat (with `CHANNEL_WIDTH` = 8).
- Hold `out_ready` = 0 after the first data beat while `in_valid` = 1. Required response: `in_ready` = 0, and `out_data`, `out_startofpacket`, `out_endofpacket` and `out_channel` are stable. When `out_ready` is released, the next byte is accepted in the same cycle with no lost or duplicated beat.
- Continuous 256-byte packet (all values 0x00–0xFF, markers escaped) with `out_ready` = 1. Required response: 256 output beats in order, data matching the original values, and no idle cycles beyond those spent on escape and marker bytes.
- Send 7A 7C then assert `reset` for one cycle, then send 41. Required response: one beat, 0x41, SOP=0, EOP=0, channel 0. All outputs are 0 during reset.
- With `CHANNEL_WIDTH` = 2, send 7C FE 7A 55. Required response: one beat, `out_channel` = 2'b10, SOP=1, data 0x55.

Source files
------------

// File: rtl/peridot_hostbridge_rxdecoder_if.sv
// peridot_hostbridge_rxdecoder_if: phy-side byte sink plus Avalon-ST packet source of the rx decoder
interface peridot_hostbridge_rxdecoder_if #(parameter int CHANNEL_WIDTH = 8);
  logic                     in_ready;
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  modport master (
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel,
    input  in_valid, in_data, out_ready
  );
  modport slave (
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel,
    output in_valid, in_data, out_ready
  );
endinterface

// File: rtl/peridot_hostbridge_rxdecoder.sv
// peridot_hostbridge_rxdecoder: strips SOP/EOP/channel/escape codes from the phy byte stream into Avalon-ST beats
module peridot_hostbridge_rxdecoder #(
  parameter int CHANNEL_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  peridot_hostbridge_rxdecoder_if.master bus
);
  logic                     sop_q, sop_d, eop_q, eop_d, chan_q, chan_d, esc_q, esc_d;
  logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;
  logic                     valid_q, valid_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [7:0]               data_q, data_d;
  logic [CHANNEL_WIDTH-1:0] ochan_q, ochan_d;
  logic                     take, mark, set_esc, set_ch, data;
  logic [7:0]               v;
  assign bus.in_ready          = !valid_q || bus.out_ready;
  assign bus.out_valid         = valid_q;
  assign bus.out_data          = data_q;
  assign bus.out_startofpacket = osop_q;
  assign bus.out_endofpacket   = oeop_q;
  assign bus.out_channel       = ochan_q;
  // an escaped byte is never a marker; under chan_pend a marker keeps the channel slot open
  always_comb begin
    take      = bus.in_valid && bus.in_ready;
    v         = esc_q ? bus.in_data ^ 8'h20 : bus.in_data;
    mark      = !esc_q && bus.in_data inside {8'h7A, 8'h7B, 8'h7C};
    set_esc   = take && !esc_q && bus.in_data == 8'h7D;
    set_ch    = take && chan_q && (esc_q || (!mark && bus.in_data != 8'h7D));
    data      = take && !set_esc && !set_ch && !mark;
    sop_d     = data ? 1'b0 : (take && mark && bus.in_data == 8'h7A) ? 1'b1 : sop_q;
    eop_d     = data ? 1'b0 : (take && mark && bus.in_data == 8'h7B) ? 1'b1 : eop_q;
    chan_d    = set_ch ? 1'b0 : (take && mark && bus.in_data == 8'h7C) ? 1'b1 : chan_q;
    esc_d     = set_esc ? 1'b1 : take ? 1'b0 : esc_q;
    channel_d = set_ch ? v[CHANNEL_WIDTH-1:0] : channel_q;
    valid_d   = data ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
    data_d    = data ? v : data_q;
    osop_d    = data ? sop_q : osop_q;
    oeop_d    = data ? eop_q : oeop_q;
    ochan_d   = data ? channel_q : ochan_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      chan_q    <= 1'b0;
      esc_q     <= 1'b0;
      channel_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= 8'h00;
      osop_q    <= 1'b0;
      oeop_q    <= 1'b0;
      ochan_q   <= '0;
    end else begin
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      chan_q    <= chan_d;
      esc_q     <= esc_d;
      channel_q <= channel_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      osop_q    <= osop_d;
      oeop_q    <= oeop_d;
      ochan_q   <= ochan_d;
    end
  end
endmodule

// File: tb/tb_peridot_hostbridge_rxdecoder.sv
// tb_peridot_hostbridge_rxdecoder: directed streams with a beat scoreboard popped by an output monitor
module tb_peridot_hostbridge_rxdecoder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  peridot_hostbridge_rxdecoder_if #(.CHANNEL_WIDTH(8)) a ();
  peridot_hostbridge_rxdecoder_if #(.CHANNEL_WIDTH(2)) b ();
  peridot_hostbridge_rxdecoder #(.CHANNEL_WIDTH(8)) dut_a (.clk(clk), .reset(reset), .bus(a));
  peridot_hostbridge_rxdecoder #(.CHANNEL_WIDTH(2)) dut_b (.clk(clk), .reset(reset), .bus(b));
  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic [7:0] c;
  } beat_t;
  beat_t      q[$];
  int         checks = 0, passed = 0, beats = 0, stalls = 0, beats0;
  logic [7:0] exp_ch = 8'h00;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  always @(negedge clk) begin
    if (!reset && a.out_valid && a.out_ready) begin
      beats++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got %h with no beat expected", a.out_data);
      end else
        chk("beat", {a.out_data, a.out_startofpacket, a.out_endofpacket, a.out_channel}, q.pop_front());
    end
  end
  task automatic send(input logic [7:0] bb);
    int   n = 0;
    logic r;
    a.in_valid = 1'b1;
    a.in_data  = bb;
    do begin
      @(negedge clk);
      r = a.in_ready;
      @(posedge clk);
      #1;
      if (!r) stalls++;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles, required accept", bb);
    end
    a.in_valid = 1'b0;
  endtask
  task automatic send2(input logic [7:0] bb);
    int   n = 0;
    logic r;
    b.in_valid = 1'b1;
    b.in_data  = bb;
    do begin
      @(negedge clk);
      r = b.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      checks++;
      $display("FAIL send2_timeout: byte %h not accepted within 50 cycles, required accept", bb);
    end
    b.in_valid = 1'b0;
  endtask
  task automatic wr(input logic [7:0] d, input logic s, input logic e);
    q.push_back({d, s, e, exp_ch});
    if (d inside {8'h7A, 8'h7B, 8'h7C, 8'h7D}) begin
      send(8'h7D);
      send(d ^ 8'h20);
    end else send(d);
  endtask
  task automatic zero_check(input string n);
    chk({n, "_valid"}, a.out_valid, 0);
    chk({n, "_data"}, a.out_data, 0);
    chk({n, "_sop"}, a.out_startofpacket, 0);
    chk({n, "_eop"}, a.out_endofpacket, 0);
    chk({n, "_chan"}, a.out_channel, 0);
  endtask
  initial begin
    int n;
    reset = 1'b1;
    a.in_valid = 1'b0; a.in_data = 8'h00; a.out_ready = 1'b1;
    b.in_valid = 1'b0; b.in_data = 8'h00; b.out_ready = 1'b1;
    @(negedge clk);
    zero_check("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", a.in_ready, 1);
    @(posedge clk); #1;
    send(8'h7A); send(8'h7C); send(8'h03);
    exp_ch = 8'h03;
    wr(8'h41, 1, 0);
    chk("latency_valid", a.out_valid, 1);
    wr(8'h42, 0, 0);
    send(8'h7B);
    wr(8'h43, 0, 1);
    send(8'h7A); send(8'h7B);
    wr(8'h7A, 1, 1);
    send(8'h7C); send(8'h7D); send(8'h5D);
    exp_ch = 8'h7D;
    wr(8'h01, 0, 0);
    send(8'h7A); send(8'h7C); send(8'h02);
    exp_ch = 8'h02;
    a.out_ready = 1'b0;
    wr(8'h11, 1, 0);
    a.in_valid = 1'b1;
    a.in_data  = 8'h22;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", a.in_ready, 0);
      chk("bp_hold", {a.out_data, a.out_startofpacket, a.out_endofpacket, a.out_channel}, {8'h11, 1'b1, 1'b0, 8'h02});
    end
    @(posedge clk); #1;
    a.out_ready = 1'b1;
    q.push_back({8'h22, 1'b0, 1'b0, exp_ch});
    send(8'h22);
    chk("no_bubble", {a.out_valid, a.out_data}, {1'b1, 8'h22});
    repeat (2) @(posedge clk);
    #1;
    beats0 = beats;
    stalls = 0;
    send(8'h7A);
    for (int i = 0; i < 256; i++) begin
      if (i == 255) send(8'h7B);
      wr(8'(i), i == 0, i == 255);
    end
    repeat (2) @(negedge clk);
    chk("stream_stalls", stalls, 0);
    chk("stream_beats", beats - beats0, 256);
    @(posedge clk); #1;
    a.out_ready = 1'b0;
    send(8'h7C); send(8'h05); send(8'h66);
    reset = 1'b1;
    @(negedge clk);
    zero_check("rst_held");
    @(posedge clk); #1;
    reset = 1'b0;
    a.out_ready = 1'b1;
    send(8'h7A); send(8'h7C);
    reset = 1'b1;
    @(negedge clk);
    zero_check("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ch = 8'h00;
    wr(8'h41, 0, 0);
    send2(8'h7C); send2(8'hFE); send2(8'h7A); send2(8'h55);
    chk("cw2_beat", {b.out_valid, b.out_data, b.out_startofpacket, b.out_endofpacket, b.out_channel},
        {1'b1, 8'h55, 1'b1, 1'b0, 2'b10});
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
